// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier with built-in controller.
// Signed WIDTH x WIDTH -> signed 2*WIDTH product, one Booth step per clock,
// start/done handshake.
//
// Optional build macro: BOOTH_ACC_EN
//   Adds the acc_en input. It is captured with start. When the captured value
//   is 1, the final step adds the new result to the held product, wrapping
//   modulo 2^(2*WIDTH), instead of overwriting it.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for start; operands are captured on the accepting edge
// CALC  | one Booth step per clock; cnt counts down, and cnt==1 is the last step
// DONE  | done pulse, product valid; start here restarts with no idle gap

module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
`ifdef BOOTH_ACC_EN
    input  logic                 acc_en,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    // A and M carry one guard bit so that A - M cannot overflow when M is
    // the most negative operand.
    logic [WIDTH:0]     a_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH:0]     m_reg;
    logic               q_m1;
    logic [CNT_W-1:0]   cnt;
`ifdef BOOTH_ACC_EN
    logic               acc_q;
`endif

    logic [WIDTH:0]       a_step;
    logic [2*WIDTH+1:0]   shift_vec;
    logic [WIDTH:0]       a_sh;
    logic [WIDTH-1:0]     q_sh;
    logic                 qm1_sh;
    logic [2*WIDTH-1:0]   booth_res;
    logic [2*WIDTH-1:0]   product_nxt;
    logic                 last_step;
    logic                 accept;

    // Add or subtract M, chosen by the Booth pair {Q[0], q_m1}
    always_comb begin
        a_step = a_reg;
        case ({q_reg[0], q_m1})
            2'b10:   a_step = a_reg - m_reg;
            2'b01:   a_step = a_reg + m_reg;
            default: a_step = a_reg;
        endcase
    end

    // Arithmetic right shift of {A', Q, q_m1}: the sign of A' is replicated
    assign shift_vec = {a_step[WIDTH], a_step, q_reg};
    assign a_sh      = shift_vec[2*WIDTH+1:WIDTH+1];
    assign q_sh      = shift_vec[WIDTH:1];
    assign qm1_sh    = shift_vec[0];
    assign booth_res = {a_sh[WIDTH-1:0], q_sh};

`ifdef BOOTH_ACC_EN
    assign product_nxt = acc_q ? (product + booth_res) : booth_res;
`else
    assign product_nxt = booth_res;
`endif

    assign last_step = (cnt == CNT_W'(1));

    // DONE also accepts start, so a held start restarts back-to-back
    assign accept = start && ((state == IDLE) || (state == DONE));

    assign busy = (state == CALC) || (state == DONE);
    assign done = (state == DONE);

    // Controller and datapath registers, with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            q_reg   <= '0;
            m_reg   <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
            product <= '0;
`ifdef BOOTH_ACC_EN
            acc_q   <= 1'b0;
`endif
        end else if (accept) begin
            m_reg <= {multiplicand[WIDTH-1], multiplicand};
            q_reg <= multiplier;
            a_reg <= '0;
            q_m1  <= 1'b0;
            cnt   <= CNT_W'(WIDTH);
`ifdef BOOTH_ACC_EN
            acc_q <= acc_en;
`endif
            state <= CALC;
        end else begin
            case (state)
                CALC: begin
                    a_reg <= a_sh;
                    q_reg <= q_sh;
                    q_m1  <= qm1_sh;
                    cnt   <= cnt - CNT_W'(1);
                    if (last_step) begin
                        product <= product_nxt;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
